// File: rtl/mrv32_pkg.sv
// Shared fetch-stage types and constants for the mrv32 front end.
package mrv32_pkg;

  localparam logic [31:0] MRV32_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] MRV32_INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_t;

  // Sequential next-fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + MRV32_INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry instruction buffer between the fetch FSM and the decoder.
// The payload only changes on load, so it stays stable while the decoder stalls.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [31:0] r_pc;

  // Valid flag: flush beats load, load beats consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload capture on load only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 32'h0;
      r_pc   <= 32'h0;
    end else if (i_load) begin
      r_data <= i_data;
      r_pc   <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, single-entry output
// buffer, JAL-style redirects with in-flight response dropping.
// Optional macro MRV32_FETCH_ALIGN_CHK_EN: flag misaligned redirect targets
// instead of silently aligning them.
module instr_fetch
  import mrv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MRV32_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_misaligned
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_redir_pc;
  logic [31:0]  w_fetch_pc;
  logic         w_mis_set;
  logic         w_blocked;
  logic         w_buf_free;
  logic         w_load;

`ifdef MRV32_FETCH_ALIGN_CHK_EN
  logic r_misaligned;

  assign w_redir_pc = redirect_pc;
  assign w_mis_set  = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky misaligned-target flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (w_mis_set) begin
      r_misaligned <= 1'b1;
    end
  end

  assign w_blocked        = r_misaligned;
  assign fetch_misaligned = r_misaligned;
`else
  logic w_unused_redir_lo;

  assign w_redir_pc        = {redirect_pc[31:2], 2'b00};
  assign w_unused_redir_lo = ^redirect_pc[1:0];
  assign w_mis_set         = 1'b0;
  assign w_blocked         = 1'b0;
  assign fetch_misaligned  = 1'b0;
`endif

  assign w_buf_free = !instr_valid || instr_ready;
  assign imem_req   = (r_state == ST_REQ);
  assign imem_addr  = r_pc;
  // pc already advanced at grant; in WAIT it can only move via a redirect,
  // and a redirect discards the response, so pc-4 is the fetched address.
  assign w_fetch_pc = r_pc - MRV32_INSTR_BYTES;

  // Next-state, next-pc and buffer-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_buf_free && !halt && !w_blocked && !w_mis_set) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = imem_gnt ? ST_DROP : ST_IDLE;
        end else if (imem_gnt) begin
          w_pc_nxt    = pc_incr(r_pc);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          // A same-cycle response is simply discarded; nothing left to drop.
          w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (redirect_valid && !w_mis_set) begin
      w_pc_nxt = w_redir_pc;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_data  (imem_rdata),
    .i_pc    (w_fetch_pc),
    .i_ready (instr_ready),
    .o_valid (instr_valid),
    .o_data  (instr),
    .o_pc    (instr_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized phase, all
// checked against a transaction-level scoreboard and a behavioural memory.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_misaligned;

  instr_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt             (halt),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory responder state
  bit          r_busy;
  int          r_rem;
  logic [31:0] r_addr;
  int          lat_cfg  = 1;
  bit          gnt_low  = 0;
  bit          gnt_rand = 0;
  bit          rdy_rand = 0;

  // Scoreboard: in-flight fetches and the expected decoder-side buffer
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } fl_t;
  fl_t         fl_q[$];
  logic [31:0] m_pc;
  bit          m_vld;
  logic [31:0] m_ipc;
  logic [31:0] m_ins;
  bit          m_mis;

  bit          ev_gnt;
  logic [31:0] ev_gaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 6) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update model and memory after.
  task automatic tick();
    bit          p_req, p_hs, p_rv, p_cons, p_redir, p_halt, p_free;
    logic [31:0] p_addr, p_rpc;
    fl_t         e;
    p_req   = imem_req;
    p_hs    = imem_req && imem_gnt;
    p_addr  = imem_addr;
    p_rv    = imem_rvalid;
    p_cons  = instr_valid && instr_ready;
    p_redir = redirect_valid;
    p_rpc   = redirect_pc;
    p_halt  = halt;
    p_free  = !instr_valid || instr_ready;
    @(posedge clk);
    #1;
    cyc++;
    ev_gnt   = p_hs;
    ev_gaddr = p_addr;
    if (p_hs) begin
      chk("one_outstanding", fl_q.size(), 0);
      chk("gnt_addr", p_addr, m_pc);
      fl_q.push_back('{p_addr, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (p_cons) m_vld = 0;
    if (p_redir) begin
      m_vld = 0;
      foreach (fl_q[i]) fl_q[i].stale = 1;
`ifdef MRV32_FETCH_ALIGN_CHK_EN
      if (p_rpc[1:0] != 2'b00) m_mis = 1;
      else m_pc = p_rpc;
`else
      m_pc = {p_rpc[31:2], 2'b00};
`endif
    end
    if (p_rv && fl_q.size() > 0) begin
      e = fl_q.pop_front();
      if (!e.stale) begin
        m_vld = 1;
        m_ipc = e.addr;
        m_ins = mem_word(e.addr);
      end
    end
    chk("instr_valid", 32'(instr_valid), 32'(m_vld));
    if (m_vld) begin
      chk("instr_pc", instr_pc, m_ipc);
      chk("instr", instr, m_ins);
    end
    chk("misaligned", 32'(fetch_misaligned), 32'(m_mis));
    if (p_req && !p_hs && !p_redir) begin
      chk("req_hold", 32'(imem_req), 1);
      chk("addr_hold", imem_addr, p_addr);
    end
    if (!p_req && imem_req) chk("req_rise_allowed", 32'(p_free && !p_halt && !m_mis), 1);
    // memory responder
    if (p_rv) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      r_busy      = 0;
    end
    if (p_hs) begin
      r_busy = 1;
      r_addr = p_addr;
      r_rem  = lat_cfg;
    end
    if (r_busy && !imem_rvalid) begin
      r_rem--;
      if (r_rem == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(r_addr);
      end
    end
    redirect_valid = 1'b0;
    imem_gnt = gnt_low ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (rdy_rand) instr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_mis", 32'(fetch_misaligned), 0);
    fl_q.delete();
    m_pc = 32'h0; m_vld = 0; m_mis = 0;
    r_busy = 0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string tag, input int lim);
    int n = 0;
    do begin tick(); n++; end while (!ev_gnt && n < lim);
    chk(tag, 32'(ev_gnt), 1);
  endtask

  task automatic wait_vld(input string tag, input int lim);
    int n = 0;
    while (!instr_valid && n < lim) begin tick(); n++; end
    chk(tag, 32'(instr_valid), 1);
  endtask

  task automatic wait_req(input string tag, input int lim);
    int n = 0;
    while (!imem_req && n < lim) begin tick(); n++; end
    chk(tag, 32'(imem_req), 1);
  endtask

  initial begin
    int          g0;
    logic [31:0] a, ga, hold_i, hold_p;
    rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // zero-wait memory: first fetch, latency, throughput
    wait_gnt("first_gnt", 10);
    chk("first_addr", ev_gaddr, 32'h0);
    g0 = cyc;
    chk("cycle2_not_valid", 32'(instr_valid), 0);
    tick();
    chk("cycle3_valid", 32'(instr_valid), 1);
    chk("first_instr_pc", instr_pc, 32'h0);
    chk("first_instr", instr, 32'h0000_0013);
    wait_gnt("second_gnt", 10);
    chk("second_addr", ev_gaddr, 32'h4);
    chk("throughput", cyc - g0, 3);

    // decoder stall holds the buffer and blocks requests
    instr_ready = 1'b0;
    wait_vld("stall_vld", 10);
    hold_i = instr; hold_p = instr_pc;
    chk("stall_pc", hold_p, 32'h4);
    chk("stall_word", hold_i, mem_word(32'h4));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", instr, hold_i);
      chk("stall_ipc", instr_pc, hold_p);
      chk("stall_noreq", 32'(imem_req), 0);
    end
    instr_ready = 1'b1;

    // redirect during WAIT drops the in-flight response
    do_reset();
    lat_cfg = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    wait_gnt("gnt_8", 10);
    chk("addr_8", ev_gaddr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    wait_gnt("gnt_100", 20);
    chk("addr_100", ev_gaddr, 32'h100);
    wait_vld("vld_100", 20);
    chk("ipc_100", instr_pc, 32'h100);

    // grant withheld for 4 cycles
    lat_cfg = 1;
    gnt_low = 1; imem_gnt = 1'b0;
    wait_req("gnt_low_req", 10);
    a = imem_addr;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nogrant_req", 32'(imem_req), 1);
      chk("nogrant_addr", imem_addr, a);
    end
    gnt_low = 0; imem_gnt = 1'b1;
    tick();
    chk("late_gnt", 32'(ev_gnt), 1);
    chk("late_gnt_addr", ev_gaddr, a);
    wait_gnt("after_late_gnt", 10);
    chk("pc_after_late", ev_gaddr, a + 32'd4);

    // halt during WAIT still buffers the response
    lat_cfg = 3;
    wait_gnt("halt_gnt", 10);
    ga = ev_gaddr;
    halt = 1'b1;
    wait_vld("halt_vld", 10);
    chk("halt_ipc", instr_pc, ga);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_noreq", 32'(imem_req), 0);
    end
    halt = 1'b0;
    wait_gnt("unhalt_gnt", 10);
    chk("unhalt_addr", ev_gaddr, ga + 32'd4);

    // pc wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    wait_gnt("wrap_gnt", 20);
    chk("wrap_top", ev_gaddr, 32'hFFFF_FFFC);
    wait_gnt("wrap_gnt2", 20);
    chk("wrap_zero", ev_gaddr, 32'h0);

    // reset mid-WAIT, then a late response must be ignored
    lat_cfg = 4;
    wait_gnt("rw_gnt", 10);
    tick();
    do_reset();
    gnt_low = 1; imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_rvalid_ignored", 32'(instr_valid), 0);
    end
    gnt_low = 0; imem_gnt = 1'b1;

    // randomized traffic
    gnt_rand = 1; rdy_rand = 1;
    for (int i = 0; i < 800; i++) begin
      lat_cfg = $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
`ifdef MRV32_FETCH_ALIGN_CHK_EN
        redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
`else
        redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
`endif
      end
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      tick();
    end
    gnt_rand = 0; rdy_rand = 0; halt = 1'b0; instr_ready = 1'b1; lat_cfg = 1;

    // misaligned redirect target
    do_reset();
    wait_gnt("mis_gnt0", 10);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
`ifdef MRV32_FETCH_ALIGN_CHK_EN
    chk("mis_flag", 32'(fetch_misaligned), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mis_noreq", 32'(imem_req), 0);
    end
`else
    chk("mis_flag_off", 32'(fetch_misaligned), 0);
    wait_gnt("mis_gnt", 10);
    chk("mis_aligned_addr", ev_gaddr, 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
